counter_arbiter: RTL

//  - Time-shares one CNT_W-bit free-running counter among NUM_REQ requesters.
//  - Each requester asks for a count of req_len cycles.
//  - A round-robin arbiter grants the counter to one requester, runs it to the requested length,

---
 rtl/counter_arbiter_pkg.sv | 14 +
 rtl/counter_arbiter_rr_arbiter.sv | 34 +++
 rtl/counter_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/counter_arbiter_pkg.sv
// Shared types and default sizing for the counter_arbiter block.
package counter_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_CNT_W   = 32;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first set request at or after ptr, wrapping.
// The pointer register itself lives in counter_arbiter.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id
);

    logic found;
    int   idx;

    // NOTE: every variable written here gets a default first; a path that skips
    // an assignment would otherwise infer a latch.
    always_comb begin
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx    = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (en && !found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gnt_id   = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/counter_arbiter.sv
// Time-shares one free-running counter among NUM_REQ requesters with round-robin grant.
// Optional macro COUNTER_ARBITER_PAUSE_EN adds a pause input that freezes COUNT.
module counter_arbiter
    import counter_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    parameter  int CNT_W   = DEF_CNT_W,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*CNT_W-1:0] req_len,
`ifdef COUNTER_ARBITER_PAUSE_EN
    input  logic                     pause,
`endif
    output logic [NUM_REQ-1:0]       grant,
    output logic                     busy,
    output logic [CNT_W-1:0]         out,
    output logic [NUM_REQ-1:0]       done,
    output logic [ID_W-1:0]          done_id
);

    state_t               state, state_d;
    logic [NUM_REQ-1:0]   grant_d, done_d, arb_gnt;
    logic [CNT_W-1:0]     out_d, limit, limit_d, cur_len;
    logic [ID_W-1:0]      id, id_d, ptr, ptr_d, next_ptr, done_id_d, arb_id;
    logic                 hold;

`ifdef COUNTER_ARBITER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req    (req),
        .ptr    (ptr),
        .en     (state == IDLE),
        .gnt    (arb_gnt),
        .gnt_id (arb_id)
    );

    assign cur_len  = req_len[int'(id)*CNT_W +: CNT_W];
    assign next_ptr = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    assign busy     = (state != IDLE);

    always_comb begin
        state_d   = state;
        grant_d   = grant;
        out_d     = out;
        limit_d   = limit;
        id_d      = id;
        ptr_d     = ptr;
        done_d    = '0;
        done_id_d = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_d = LOAD;
                    grant_d = arb_gnt;
                    id_d    = arb_id;
                end
            end
            LOAD: begin
                limit_d = cur_len;
                out_d   = '0;
                if (cur_len == '0) begin
                    state_d   = DONE;
                    done_d    = grant;
                    done_id_d = id;
                end else begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                // Abort outranks both pause and completion.
                if (!req[id]) begin
                    state_d = IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                end else if (!hold) begin
                    out_d = out + CNT_W'(1);
                    if (out == limit - CNT_W'(1)) begin
                        state_d   = DONE;
                        done_d    = grant;
                        done_id_d = id;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                ptr_d   = next_ptr;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            grant   <= '0;
            out     <= '0;
            limit   <= '0;
            id      <= '0;
            ptr     <= '0;
            done    <= '0;
            done_id <= '0;
        end else begin
            state   <= state_d;
            grant   <= grant_d;
            out     <= out_d;
            limit   <= limit_d;
            id      <= id_d;
            ptr     <= ptr_d;
            done    <= done_d;
            done_id <= done_id_d;
        end
    end

endmodule
